// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared types and helpers for the stream-to-burst packing logic.
//   burst_state_t  : packer FSM states (IDLE, CMD, DATA)
//   BYTES_PER_BEAT : byte width of one beat at the default data width
//   bytes_per_beat : byte width of one beat for an arbitrary data width
// -----------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } burst_state_t;

    localparam int PKG_DW         = 32;
    localparam int BYTES_PER_BEAT = PKG_DW / 8;

    // Byte stride of one beat for a given data width.
    function automatic int bytes_per_beat(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/stream_burst_packer.sv
// -----------------------------------------------------------------------------
// stream_burst_packer
// Drains a valid/ready stream from an upstream FIFO and emits memory write
// bursts: one command beat (address, beats-1) followed by exactly that many
// data beats, the final one flagged last. A full burst is issued as soon as
// the FIFO holds BURST words; a partial burst of everything buffered is
// issued on flush or after TIMEOUT idle cycles with data waiting.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   base_addr, addr_load  : address register load (honoured in IDLE only)
//   flush                 : level request for a partial burst
//   in_data/valid/ready   : upstream stream
//   in_cnt                : upstream occupancy (AW+1 bits)
//   cmd_addr/len/valid/ready : burst command channel (len = beats-1)
//   wr_data/last/valid/ready : burst data channel (pass-through)
//   busy                  : FSM not in IDLE
//   beats_total           : data beats transferred since reset (wraps)
// -----------------------------------------------------------------------------
module stream_burst_packer
    import stream_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int BURST   = 16,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              addr_load,
    input  logic              flush,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW:0]       in_cnt,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DW-1:0]     wr_data,
    output logic              wr_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              busy,
    output logic [31:0]       beats_total
);

    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP_BYTES = ADDR_W'(bytes_per_beat(DW));
    localparam logic [LW-1:0]     BURST_LEN  = LW'(BURST);
    localparam logic [TW-1:0]     TMR_FIRE   = TW'(TIMEOUT - 1);

    burst_state_t      state_r;
    burst_state_t      state_s;
    logic [TW-1:0]     tmr_r;
    logic [LW-1:0]     beat_r;
    logic [LW-1:0]     len_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [7:0]        cmd_len_r;
    logic [31:0]       beats_total_r;

    logic              full_s;
    logic              part_s;
    logic              decide_s;
    logic [LW-1:0]     len_pick_s;
    logic              beat_fire_s;
    logic              last_beat_s;

    // IDLE burst decision: full burst has priority over a partial one.
    always_comb begin
        full_s      = 1'b0;
        part_s      = 1'b0;
        decide_s    = 1'b0;
        len_pick_s  = BURST_LEN;
        full_s      = (in_cnt >= BURST_LEN);
        part_s      = (in_cnt != '0) && (flush || (tmr_r == TMR_FIRE));
        decide_s    = (state_r == IDLE) && (full_s || part_s);
        if (full_s) begin
            len_pick_s = BURST_LEN;
        end else begin
            len_pick_s = in_cnt;
        end
    end

    // Data-phase beat qualification.
    always_comb begin
        beat_fire_s = 1'b0;
        last_beat_s = 1'b0;
        beat_fire_s = (state_r == DATA) && in_valid && wr_ready;
        last_beat_s = (beat_r == (len_r - LW'(1)));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (decide_s) begin
                    state_s = CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    state_s = DATA;
                end else begin
                    state_s = CMD;
                end
            end
            DATA: begin
                if (beat_fire_s && last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Idle timer: counts while a partial amount is buffered, saturates at the
    // firing value so a long stall cannot wrap it back past the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_r <= '0;
        end else if ((state_r != IDLE) || (in_cnt == '0) || decide_s) begin
            tmr_r <= '0;
        end else if ((in_cnt < BURST_LEN) && (tmr_r != TMR_FIRE)) begin
            tmr_r <= tmr_r + TW'(1);
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Running write address: loaded in IDLE, advanced after each burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
        end else if ((state_r == IDLE) && addr_load) begin
            addr_r <= base_addr;
        end else if (beat_fire_s && last_beat_s) begin
            addr_r <= addr_r + (ADDR_W'(len_r) * STEP_BYTES);
        end else begin
            addr_r <= addr_r;
        end
    end

    // Command capture at the decision; a simultaneous load wins over addr_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr_r <= '0;
            cmd_len_r  <= 8'd0;
            len_r      <= '0;
        end else if (decide_s) begin
            cmd_addr_r <= addr_load ? base_addr : addr_r;
            cmd_len_r  <= 8'(len_pick_s - LW'(1));
            len_r      <= len_pick_s;
        end else begin
            cmd_addr_r <= cmd_addr_r;
            cmd_len_r  <= cmd_len_r;
            len_r      <= len_r;
        end
    end

    // Beat index within the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= '0;
        end else if (beat_fire_s) begin
            if (last_beat_s) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + LW'(1);
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    // Lifetime transferred-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_total_r <= 32'd0;
        end else if (beat_fire_s) begin
            beats_total_r <= beats_total_r + 32'd1;
        end else begin
            beats_total_r <= beats_total_r;
        end
    end

    // Data path is a zero-latency pass-through, gated to the DATA state.
    assign in_ready    = (state_r == DATA) ? wr_ready : 1'b0;
    assign wr_valid    = (state_r == DATA) ? in_valid : 1'b0;
    assign wr_data     = in_data;
    assign wr_last     = (state_r == DATA) && last_beat_s;
    assign cmd_valid   = (state_r == CMD);
    assign cmd_addr    = cmd_addr_r;
    assign cmd_len     = cmd_len_r;
    assign busy        = (state_r != IDLE);
    assign beats_total = beats_total_r;

endmodule

// File: tb/tb_stream_burst_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_burst_packer
// Self-checking bench for stream_burst_packer. A simple upstream FIFO model
// feeds the DUT; every pushed word is also queued as an expected beat and
// popped when the DUT transfers a beat.
// -----------------------------------------------------------------------------
module tb_stream_burst_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] base_addr = 32'd0;
    logic        addr_load = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_cnt;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic        busy;
    logic [31:0] beats_total;

    int checks = 0;
    int errors = 0;
    int exp_total = 0;
    logic [31:0] exp_q[$];

    // Upstream FIFO model
    logic [31:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign in_cnt   = 9'(wr_ptr - rd_ptr);
    assign in_valid = (wr_ptr != rd_ptr);
    assign in_data  = mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (in_valid && in_ready) rd_ptr <= rd_ptr + 1;
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    stream_burst_packer #(
        .DW(32), .AW(8), .BURST(16), .ADDR_W(32), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .base_addr(base_addr), .addr_load(addr_load),
        .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_cnt(in_cnt), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .busy(busy), .beats_total(beats_total)
    );

    task automatic push_word(input logic [31:0] v);
        mem[wr_ptr % 1024] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
    endtask

    // Waits for a command, checks it, optionally holds it, then transfers up
    // to max_beats data beats against the scoreboard.
    task automatic collect(input logic [31:0] e_addr, input int e_len,
                           input int hold, input bit rnd, input int max_beats,
                           output int waited);
        bit seen;
        int got;
        logic [31:0] e;
        seen = 1'b0;
        waited = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            waited = n + 1;
            if (cmd_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cmd_wait: cmd_valid=0 after %0d cycles, required 1", waited);
            return;
        end
        checks++;
        if (cmd_addr !== e_addr) begin
            errors++;
            $display("FAIL cmd_addr: got %h required %h", cmd_addr, e_addr);
        end
        checks++;
        if (cmd_len !== 8'(e_len - 1)) begin
            errors++;
            $display("FAIL cmd_len: got %0d required %0d", cmd_len, e_len - 1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_addr !== e_addr || cmd_len !== 8'(e_len - 1)) begin
                errors++;
                $display("FAIL cmd_stable: valid=%b addr=%h len=%0d required 1 %h %0d",
                         cmd_valid, cmd_addr, cmd_len, e_addr, e_len - 1);
            end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        got = 0;
        for (int c = 0; c < 400 && got < max_beats; c++) begin
            wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checks++;
            if (in_ready !== wr_ready) begin
                errors++;
                $display("FAIL in_ready: got %b required %b", in_ready, wr_ready);
            end
            if (wr_valid === 1'b1 && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h required none", wr_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (wr_data !== e) begin
                        errors++;
                        $display("FAIL wr_data: got %h required %h", wr_data, e);
                    end
                    checks++;
                    if (wr_last !== (got == e_len - 1)) begin
                        errors++;
                        $display("FAIL wr_last: beat %0d got %b required %b",
                                 got, wr_last, (got == e_len - 1));
                    end
                end
                got++;
                exp_total++;
            end
            @(negedge clk);
        end
        wr_ready = 1'b0;
        checks++;
        if (got != max_beats) begin
            errors++;
            $display("FAIL beat_count: got %0d required %0d", got, max_beats);
        end
        checks++;
        if (beats_total !== 32'(exp_total)) begin
            errors++;
            $display("FAIL beats_total: got %0d required %0d", beats_total, exp_total);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, cmd_valid, wr_valid, in_ready, wr_last} !== 5'b0 ||
            cmd_addr !== 32'd0 || cmd_len !== 8'd0 || beats_total !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b cv=%b wv=%b ir=%b wl=%b addr=%h len=%0d tot=%0d required all 0",
                     busy, cmd_valid, wr_valid, in_ready, wr_last, cmd_addr, cmd_len, beats_total);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int w;
        for (int i = 0; i < 16; i++) push_word(32'hA000 + 32'(i));
        collect(32'h0, 16, 10, 1'b1, 16, w);
        checks++;
        if (beats_total !== 32'd16) begin
            errors++;
            $display("FAIL bp_total: got %0d required 16", beats_total);
        end
    endtask

    task automatic test_full_burst();
        int w;
        base_addr = 32'h1000;
        addr_load = 1'b1;
        for (int i = 0; i < 32; i++) push_word(32'(i));
        @(negedge clk);
        addr_load = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: cmd_valid got %b required 1", cmd_valid);
        end
        collect(32'h1000, 16, 0, 1'b0, 16, w);
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: cmd_valid=%b busy=%b required 0 0", cmd_valid, busy);
        end
        collect(32'h1040, 16, 0, 1'b0, 16, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL b2b_latency: got %0d required 1", w);
        end
    endtask

    task automatic test_timeout();
        int w;
        for (int i = 0; i < 3; i++) push_word(32'hB000 + 32'(i));
        collect(32'h1080, 3, 0, 1'b0, 3, w);
        checks++;
        if (w != 64) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d required 64", w);
        end
    endtask

    task automatic test_flush();
        int w;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty: cmd_valid=%b busy=%b required 0 0", cmd_valid, busy);
            end
        end
        flush = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'hC000 + 32'(i));
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_early: cmd_valid got %b required 0", cmd_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_len !== 8'd4) begin
            errors++;
            $display("FAIL flush_cmd: cmd_valid=%b len=%0d required 1 4", cmd_valid, cmd_len);
        end
        collect(32'h108C, 5, 0, 1'b0, 5, w);
    endtask

    task automatic test_wrap();
        int w;
        base_addr = 32'hFFFF_FFE0;
        addr_load = 1'b1;
        @(negedge clk);
        addr_load = 1'b0;
        for (int i = 0; i < 32; i++) push_word(32'hD000 + 32'(i));
        collect(32'hFFFF_FFE0, 16, 0, 1'b0, 16, w);
        collect(32'h0000_0020, 16, 0, 1'b0, 16, w);
    endtask

    task automatic test_reset_mid_data();
        int w;
        for (int i = 0; i < 16; i++) push_word(32'hE000 + 32'(i));
        collect(32'h60, 16, 0, 1'b0, 7, w);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || beats_total !== 32'd0 ||
            wr_valid !== 1'b0 || in_ready !== 1'b0 || wr_last !== 1'b0 ||
            cmd_addr !== 32'd0 || cmd_len !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b cv=%b tot=%0d wv=%b ir=%b wl=%b addr=%h len=%0d required all 0",
                     busy, cmd_valid, beats_total, wr_valid, in_ready, wr_last, cmd_addr, cmd_len);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_total = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_word(32'hF000 + 32'(i));
        collect(32'h0, 16, 0, 1'b0, 16, w);
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_full_burst();
        test_timeout();
        test_flush();
        test_wrap();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
